// File: rtl/apb_mem_bridge.sv
// apb_mem_bridge: APB completer that drives a 256x8 synchronous-read memory port.
// Optional write protection is enabled by defining APB_MEM_WPROT_EN (protects WPROT_BASE and up).
module apb_mem_bridge
`ifdef APB_MEM_WPROT_EN
#(
    parameter logic [7:0] WPROT_BASE = 8'hF0
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wr_data,
    output logic       mem_ce,
    output logic       mem_wren,
    output logic       mem_rden,
    input  logic [7:0] mem_rd_data,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR     = 3'd1,
        S_RD     = 3'd2,
        S_RD_CAP = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_setup;
    logic   w_prot;

    // Handshake: a transfer starts when psel=1,penable=0 is sampled in IDLE and
    // completes on the edge where psel=1,penable=1 is sampled while pready=1.
    assign w_setup = psel && !penable;

`ifdef APB_MEM_WPROT_EN
    logic r_err;

    assign w_prot  = pwrite && (paddr >= WPROT_BASE);
    assign pslverr = (r_state == S_RESP) && r_err;
`else
    assign w_prot  = 1'b0;
    assign pslverr = 1'b0;
`endif

    assign dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            mem_addr    <= 8'h00;
            mem_wr_data <= 8'h00;
            prdata      <= 8'h00;
`ifdef APB_MEM_WPROT_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_setup) begin
                mem_addr    <= paddr;
                mem_wr_data <= pwdata;
`ifdef APB_MEM_WPROT_EN
                r_err       <= w_prot;
`endif
            end
            // Capture happens even when the transfer is being aborted.
            if (r_state == S_RD_CAP) begin
                prdata <= mem_rd_data;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        mem_ce   = 1'b0;
        mem_wren = 1'b0;
        mem_rden = 1'b0;
        pready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    if (pwrite) begin
                        w_next = w_prot ? S_RESP : S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_WR: begin
                mem_ce   = 1'b1;
                mem_wren = 1'b1;
                w_next   = S_RESP;
            end
            S_RD: begin
                mem_ce   = 1'b1;
                mem_rden = 1'b1;
                w_next   = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_next = psel ? S_RESP : S_IDLE;
            end
            S_RESP: begin
                pready = 1'b1;
                if (!psel || penable) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
